// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the pattern generator / 1011 detector demo block.
package seq_detect_pkg;

  localparam int unsigned PATTERN_LEN = 16;
  localparam logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = 16'hB65C;

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } det_state_t;

endpackage

// File: rtl/seq_detect_if.sv
// Bit-stream bundle: generated stream x and match flag y.
interface seq_detect_if;

  logic x;
  logic y;

  modport master (output x, output y);
  modport slave  (input  x, input  y);

endinterface

// File: rtl/seq_detect_system_detector.sv
// Moore FSM flagging each completed (overlapping) 1011 on the sampled input stream.
module sequence_detector
  import seq_detect_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic y
);

  det_state_t r_state;
  det_state_t w_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S0;
    unique case (r_state)
      S0:      w_next = x ? S1    : S0;
      S1:      w_next = x ? S1    : S10;
      S10:     w_next = x ? S101  : S0;
      S101:    w_next = x ? S1011 : S10;
      S1011:   w_next = x ? S1    : S10;
      // Unreachable encodings fall back to idle.
      default: w_next = S0;
    endcase
  end

  assign y = (r_state == S1011);

endmodule

// File: rtl/seq_detect_system_generator.sv
// Rotating pattern source: emits PATTERN MSB first, repeating every PATTERN_LEN clocks.
module sequence_generator
  import seq_detect_pkg::*;
#(
  parameter logic [PATTERN_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic clk,
  input  logic reset,
  output logic seq
);

  logic [PATTERN_LEN-1:0] r_sreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sreg <= PATTERN;
    end else begin
      r_sreg <= {r_sreg[PATTERN_LEN-2:0], r_sreg[PATTERN_LEN-1]};
    end
  end

  assign seq = r_sreg[PATTERN_LEN-1];

endmodule

// File: rtl/seq_detect_system.sv
// Thin wrapper: generator stream feeds both the detector and the top-level x output.
module seq_detect_system
  import seq_detect_pkg::*;
#(
  parameter logic [PATTERN_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic clk,
  input  logic reset,
  output logic x,
  output logic y
);

  seq_detect_if u_bus ();

  sequence_generator #(
    .PATTERN (PATTERN)
  ) u_gen (
    .clk   (clk),
    .reset (reset),
    .seq   (u_bus.x)
  );

  sequence_detector u_det (
    .clk   (clk),
    .reset (reset),
    .x     (u_bus.x),
    .y     (u_bus.y)
  );

  assign x = u_bus.x;
  assign y = u_bus.y;

endmodule

// File: tb/tb_seq_detect_system.sv
// Directed + randomized checks of generator stream and 1011 detection against a stream model.
module tb_seq_detect_system;
  import seq_detect_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset    = 1'b1;
  logic reset_ff = 1'b1;
  logic det_reset = 1'b1;
  logic det_x    = 1'b0;
  logic det_y;

  seq_detect_if bus ();
  seq_detect_if bus_ff ();

  seq_detect_system u_top (
    .clk   (clk),
    .reset (reset),
    .x     (bus.x),
    .y     (bus.y)
  );

  seq_detect_system #(
    .PATTERN (16'hFFFF)
  ) u_top_ff (
    .clk   (clk),
    .reset (reset_ff),
    .x     (bus_ff.x),
    .y     (bus_ff.y)
  );

  sequence_detector u_det (
    .clk   (clk),
    .reset (det_reset),
    .x     (det_x),
    .y     (det_y)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stream index since reset plus the last consumed bits.
  logic [15:0] pat = 16'hB65C;
  int k = 0;
  bit hist[$];
  bit dhist[$];

  function automatic logic model_x(int idx);
    int pos;
    pos = 15 - (idx % 16);
    return pat[pos];
  endfunction

  function automatic logic match4(bit q[$]);
    if (q.size() < 4) return 1'b0;
    return (q[q.size()-4] == 1'b1) && (q[q.size()-3] == 1'b0) &&
           (q[q.size()-2] == 1'b1) && (q[q.size()-1] == 1'b1);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic top_reset(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    k = 0;
    hist.delete();
    check({tag, "_x"}, bus.x, 1'b1);
    check({tag, "_y"}, bus.y, 1'b0);
  endtask

  task automatic top_step(input string tag);
    hist.push_back(model_x(k));
    if (hist.size() > 4) void'(hist.pop_front());
    k++;
    tick();
    check({tag, "_x"}, bus.x, model_x(k));
    check({tag, "_y"}, bus.y, match4(hist));
  endtask

  task automatic det_feed(input string tag, input bit b);
    det_x = b;
    dhist.push_back(b);
    if (dhist.size() > 4) void'(dhist.pop_front());
    tick();
    check(tag, det_y, match4(dhist));
  endtask

  task automatic det_restart();
    det_reset = 1'b1;
    tick();
    det_reset = 1'b0;
    dhist.delete();
    check("det_reset_y", det_y, 1'b0);
  endtask

  initial begin
    bit ovl[7];
    bit rec[8];
    bit ovl_exp[7];
    bit rec_exp[8];

    // Reset and first period against the literal stream.
    top_reset("reset");
    for (int i = 1; i < 16; i++) begin
      top_step("first_period");
    end

    // Steady state: pulses only at stream positions 4, 7, 13 of each period.
    top_reset("steady_reset");
    for (int i = 1; i <= 48; i++) begin
      top_step("steady");
      check("steady_pulse_pos", bus.y, ((k % 16) == 4) || ((k % 16) == 7) || ((k % 16) == 13));
    end

    // Mid-run reset sampled at E6 aborts the partial match.
    top_reset("mid_pre");
    for (int i = 1; i <= 5; i++) top_step("mid_pre");
    top_reset("mid_reset");
    for (int i = 1; i <= 20; i++) begin
      top_step("mid_post");
      if (i <= 3) check("mid_no_stale_pulse", bus.y, 1'b0);
      if (i == 4) check("mid_first_pulse", bus.y, 1'b1);
    end

    // Randomized reset placement over a long run.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        top_reset("rand_reset");
      end else begin
        top_step("rand_run");
      end
    end

    // Standalone detector: overlap case.
    ovl     = '{1, 0, 1, 1, 0, 1, 1};
    ovl_exp = '{0, 0, 0, 1, 0, 0, 1};
    det_restart();
    for (int i = 0; i < 7; i++) begin
      det_feed("det_overlap", ovl[i]);
      check("det_overlap_const", det_y, ovl_exp[i]);
    end

    // Standalone detector: partial-match recovery.
    rec     = '{1, 0, 1, 0, 1, 1, 1, 1};
    rec_exp = '{0, 0, 0, 0, 0, 1, 0, 0};
    det_restart();
    for (int i = 0; i < 8; i++) begin
      det_feed("det_recover", rec[i]);
      check("det_recover_const", det_y, rec_exp[i]);
    end

    // Standalone detector: random bits, with occasional reset.
    det_restart();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) det_restart();
      else det_feed("det_random", 1'($urandom_range(0, 1)));
    end

    // All-ones pattern never matches; detector parks in S1.
    reset_ff = 1'b1;
    tick();
    reset_ff = 1'b0;
    check("ff_reset_x", bus_ff.x, 1'b1);
    check("ff_reset_y", bus_ff.y, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("ff_x", bus_ff.x, 1'b1);
      check("ff_y", bus_ff.y, 1'b0);
      check("ff_state_s1", logic'(u_top_ff.u_det.r_state == S1), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
